vga_timing_gen: RTL

//  Parametrised VGA/VESA raster timing generator. Sync widths, porches, sync polarity and

---
 rtl/vga_timing_gen.sv | 133 +++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/VESA raster timing generator: pixel strobe, x/y, syncs, video_on, line/frame strobes.
// Define VGA_TEST_PATTERN_EN to drive 8 vertical colour bars on rgb; otherwise rgb is tied to zero.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CW      = 11,
  parameter int unsigned H_DISP  = 640,
  parameter int unsigned H_FP    = 16,
  parameter int unsigned H_SYNC  = 96,
  parameter int unsigned H_BP    = 48,
  parameter int unsigned V_DISP  = 480,
  parameter int unsigned V_FP    = 10,
  parameter int unsigned V_SYNC  = 2,
  parameter int unsigned V_BP    = 33,
  parameter logic        H_POL   = 1'b0,
  parameter logic        V_POL   = 1'b0
) (
  input  logic          clk_100Mhz,
  input  logic          reset_n,
  input  logic          en,
  output logic          p_tick,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic          line_end,
  output logic          frame_end,
  output logic [11:0]   rgb
);

  localparam int unsigned H_TOTAL  = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_DISP + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_DISP + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic             p_tick_q, p_tick_d;
  logic [CW-1:0]    x_q, x_d, y_q, y_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             video_on_q, video_on_d;

  // Next-state: divider, raster position, and syncs derived from the next position.
  always_comb begin
    div_d    = div_q;
    p_tick_d = 1'b0;
    x_d      = x_q;
    y_d      = y_q;
    if (en) begin
      p_tick_d = (div_q == DIV_W'(CLK_DIV - 1));
      div_d    = p_tick_d ? '0 : div_q + DIV_W'(1);
    end
    if (p_tick_q) begin
      if (x_q == CW'(H_TOTAL - 1)) begin
        x_d = '0;
        y_d = (y_q == CW'(V_TOTAL - 1)) ? '0 : y_q + CW'(1);
      end else begin
        x_d = x_q + CW'(1);
      end
    end
    hsync_d    = ((x_d >= CW'(HS_START)) && (x_d < CW'(HS_END))) ? H_POL : ~H_POL;
    vsync_d    = ((y_d >= CW'(VS_START)) && (y_d < CW'(VS_END))) ? V_POL : ~V_POL;
    video_on_d = en && (x_d < CW'(H_DISP)) && (y_d < CW'(V_DISP));
  end

  always_ff @(posedge clk_100Mhz) begin
    if (!reset_n) begin
      div_q      <= '0;
      p_tick_q   <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      hsync_q    <= ~H_POL;
      vsync_q    <= ~V_POL;
      video_on_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      p_tick_q   <= p_tick_d;
      x_q        <= x_d;
      y_q        <= y_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      video_on_q <= video_on_d;
    end
  end

  assign p_tick    = p_tick_q;
  assign x         = x_q;
  assign y         = y_q;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign video_on  = video_on_q;
  // Strobes mark the last tick of a line/frame, so they must see the current position.
  assign line_end  = p_tick_q && (x_q == CW'(H_TOTAL - 1));
  assign frame_end = line_end && (y_q == CW'(V_TOTAL - 1));

`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned BAR_W = H_DISP / 8;

  logic [2:0]  bar_idx;
  logic [11:0] rgb_q, rgb_d;

  // Colour bars from the next x so the pattern stays aligned with x/video_on.
  always_comb begin
    bar_idx = 3'(x_d / CW'(BAR_W));
    rgb_d   = 12'h000;
    if (video_on_d) begin
      case (bar_idx)
        3'd0:    rgb_d = 12'hFFF;
        3'd1:    rgb_d = 12'hFF0;
        3'd2:    rgb_d = 12'h0FF;
        3'd3:    rgb_d = 12'h0F0;
        3'd4:    rgb_d = 12'hF0F;
        3'd5:    rgb_d = 12'hF00;
        3'd6:    rgb_d = 12'h00F;
        default: rgb_d = 12'h000;
      endcase
    end
  end

  always_ff @(posedge clk_100Mhz) begin
    if (!reset_n) rgb_q <= 12'h000;
    else          rgb_q <= rgb_d;
  end

  assign rgb = rgb_q;
`else
  assign rgb = 12'h000;
`endif

endmodule
